// File: rtl/spi_arb_pkg.sv
// Shared encodings for the SPI memory arbiter: FSM states, owner tags, device codes
// and the fixed read-data values returned without an SPI transaction.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA
  } owner_t;

  localparam logic DEV_FLASH = 1'b0;
  localparam logic DEV_RAM   = 1'b1;

  localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/spi_arb_decode.sv
// Address-region decode for one requester port: selects flash or RAM and flags
// unmapped regions and writes aimed at flash.
module spi_arb_decode
  import spi_arb_pkg::*;
#(
  parameter logic [3:0] FLASH_REGION = 4'h8,
  parameter logic [3:0] RAM_REGION   = 4'h0
) (
  input  logic [3:0] region,
  input  logic       we,
  output logic       dev,
  output logic       err
);

  logic hit_flash;
  logic hit_ram;

  always_comb begin
    hit_flash = (region == FLASH_REGION);
    hit_ram   = (region == RAM_REGION);
    dev       = hit_ram ? DEV_RAM : DEV_FLASH;
    err       = !(hit_flash || hit_ram) || (we && hit_flash);
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI transaction engine between the fetch and load/store ports.
// Optional WAIT-state watchdog with spi_abort is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_mem_arbiter
  import spi_arb_pkg::*;
#(
  parameter int         MAX_DATA_BURST = 4,
  parameter logic [3:0] FLASH_REGION   = 4'h8,
  parameter logic [3:0] RAM_REGION     = 4'h0,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_done,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        data_err,
  output logic        spi_start,
  output logic        spi_dev,
  output logic        spi_we,
  output logic [23:0] spi_addr,
  output logic [31:0] spi_wdata,
  input  logic        spi_done,
  input  logic [31:0] spi_rdata,
  output logic        spi_abort
);

  localparam int SC_W = $clog2(MAX_DATA_BURST + 1);

  arb_state_t      state, state_nxt;
  owner_t          owner;
  logic [SC_W-1:0] starve_cnt;
  logic            err_q;
  logic            instr_dev, instr_dec_err;
  logic            data_dev, data_dec_err;
  logic            grant_data, grant_instr;
  logic            timeout_hit;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{instr_addr[27:24], data_addr[27:24]};

  spi_arb_decode #(.FLASH_REGION(FLASH_REGION), .RAM_REGION(RAM_REGION)) u_dec_instr (
    .region (instr_addr[31:28]),
    .we     (1'b0),
    .dev    (instr_dev),
    .err    (instr_dec_err)
  );

  spi_arb_decode #(.FLASH_REGION(FLASH_REGION), .RAM_REGION(RAM_REGION)) u_dec_data (
    .region (data_addr[31:28]),
    .we     (data_we),
    .dev    (data_dev),
    .err    (data_dec_err)
  );

  // Data wins unless the fetch port has already waited out a full data burst
  always_comb begin
    grant_data  = data_req && (!instr_req || (starve_cnt < SC_W'(MAX_DATA_BURST)));
    grant_instr = instr_req && !grant_data;
  end

  always_comb begin
    state_nxt  = state;
    spi_start  = 1'b0;
    instr_done = 1'b0;
    data_done  = 1'b0;
    data_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (grant_data)       state_nxt = data_dec_err  ? ST_RESP : ST_ISSUE;
        else if (grant_instr) state_nxt = instr_dec_err ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        spi_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (spi_done || timeout_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        instr_done = (owner == OWN_INSTR);
        data_done  = (owner == OWN_DATA);
        data_err   = (owner == OWN_DATA) && err_q;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= OWN_NONE;
      starve_cnt  <= '0;
      err_q       <= 1'b0;
      spi_dev     <= 1'b0;
      spi_we      <= 1'b0;
      spi_addr    <= '0;
      spi_wdata   <= '0;
      instr_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      state <= state_nxt;

      if (!instr_req || (state == ST_IDLE && grant_instr))
        starve_cnt <= '0;
      else if (state == ST_IDLE && grant_data && starve_cnt < SC_W'(MAX_DATA_BURST))
        starve_cnt <= starve_cnt + 1'b1;

      // Transaction fields are latched once at grant and held until the next grant
      if (state == ST_IDLE && grant_data) begin
        owner     <= OWN_DATA;
        err_q     <= data_dec_err;
        spi_dev   <= data_dev;
        spi_we    <= data_we;
        spi_addr  <= data_addr[23:0];
        spi_wdata <= data_wdata;
        if (data_dec_err) data_rdata <= '0;
      end else if (state == ST_IDLE && grant_instr) begin
        owner     <= OWN_INSTR;
        err_q     <= instr_dec_err;
        spi_dev   <= instr_dev;
        spi_we    <= 1'b0;
        spi_addr  <= instr_addr[23:0];
        spi_wdata <= '0;
        if (instr_dec_err) instr_rdata <= INSTR_NOP;
      end

      if (state == ST_WAIT && (spi_done || timeout_hit)) begin
        if (owner == OWN_INSTR) instr_rdata <= spi_done ? spi_rdata : TIMEOUT_RDATA;
        else                    data_rdata  <= spi_done ? spi_rdata : TIMEOUT_RDATA;
        if (!spi_done) err_q <= 1'b1;
      end

      if (state == ST_RESP) owner <= OWN_NONE;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WC_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || state != ST_WAIT) wait_cnt <= '0;
    else                            wait_cnt <= wait_cnt + 1'b1;
  end

  // wait_cnt is 0 in the first WAIT cycle, so the limit fires in WAIT cycle TIMEOUT_CYCLES
  assign timeout_hit = (state == ST_WAIT) && !spi_done &&
                       (wait_cnt == WC_W'(TIMEOUT_CYCLES - 1));
  assign spi_abort   = timeout_hit;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign spi_abort   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter: vector table, fairness and reset sequences,
// randomized transactions against a region-rule model; watchdog cases with SPI_ARB_TIMEOUT_EN.
module tb_spi_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req, data_req, data_we;
  logic [31:0] instr_addr, data_addr, data_wdata;
  logic [31:0] instr_rdata, data_rdata, spi_wdata, spi_rdata;
  logic        instr_done, data_done, data_err;
  logic        spi_start, spi_dev, spi_we, spi_done, spi_abort;
  logic [23:0] spi_addr;

  spi_mem_arbiter #(
    .MAX_DATA_BURST (MAXB),
    .FLASH_REGION   (4'h8),
    .RAM_REGION     (4'h0),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_rdata (instr_rdata),
    .instr_done  (instr_done),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_done   (data_done),
    .data_err    (data_err),
    .spi_start   (spi_start),
    .spi_dev     (spi_dev),
    .spi_we      (spi_we),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_done    (spi_done),
    .spi_rdata   (spi_rdata),
    .spi_abort   (spi_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // SPI engine model: answers each start after eng_lat cycles and records what was issued
  bit          eng_en = 1'b1;
  int          eng_lat = 1;
  logic [31:0] eng_rdata = '0;
  int          n_start = 0;
  int          unstable = 0;
  logic        cap_dev, cap_we;
  logic [23:0] cap_addr;
  logic [31:0] cap_wdata;
  bit          order[$];

  initial begin
    spi_done  = 1'b0;
    spi_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (spi_start) begin
        n_start++;
        cap_dev = spi_dev; cap_we = spi_we; cap_addr = spi_addr; cap_wdata = spi_wdata;
        order.push_back(spi_dev);
        if (eng_en) begin
          for (int k = 0; k < eng_lat; k++) begin
            @(posedge clk);
            #1;
            if ({spi_dev, spi_we, spi_addr, spi_wdata} !== {cap_dev, cap_we, cap_addr, cap_wdata})
              unstable++;
          end
          spi_done  = 1'b1;
          spi_rdata = eng_rdata;
          @(posedge clk);
          #1;
          spi_done  = 1'b0;
          spi_rdata = '0;
        end
      end
    end
  end

  int n_abort = 0;
  int abort_cyc = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (spi_abort) begin
      n_abort++;
      abort_cyc = cyc;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Region rules: flash 0x8, RAM 0x0; everything else, and data writes to flash, skip the engine
  function automatic void ref_model(input bit is_d, input bit we, input logic [31:0] addr,
                                    input logic [31:0] erd, output bit st, output bit dev,
                                    output logic [31:0] rd, output bit err);
    int region;
    region = int'(addr >> 28);
    st  = (region == 0) || (region == 8 && !(is_d && we));
    dev = (region == 0);
    err = is_d && !st;
    rd  = st ? erd : (is_d ? 32'h0 : 32'h0000_0013);
  endfunction

  task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int bound,
                         output logic [31:0] rd, output logic err, output int lat,
                         output int starts);
    int  s0, c0;
    bit  seen;
    s0 = n_start;
    if (is_d) begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
    end else begin
      instr_req = 1'b1; instr_addr = addr;
    end
    c0 = cyc; seen = 1'b0; lat = -1; rd = '0; err = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      tick();
      if (is_d ? data_done : instr_done) begin
        seen = 1'b1;
        lat  = cyc - c0;
        rd   = is_d ? data_rdata : instr_rdata;
        err  = data_err;
      end
    end
    data_req  = 1'b0;
    instr_req = 1'b0;
    tick();
    check("done_is_one_cycle", {31'b0, (is_d ? data_done : instr_done)}, 32'h0);
    starts = n_start - s0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] erd;
    bit          x_start;
    bit          x_dev;
    logic [31:0] x_rd;
    bit          x_err;
    int          x_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, st, s0, nd, sc;
    bit          exp_dev;

    vecs[0] = '{1'b0, 1'b0, 32'h8000_0100, 32'h0,          10, 32'h0000_0513, 1'b1, 1'b0, 32'h0000_0513, 1'b0, 12};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678,  3, 32'hA5A5_0001, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0,  5};
    vecs[2] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_0000,  3, 32'h1111_1111, 1'b0, 1'b0, 32'h0,          1'b1,  1};
    vecs[3] = '{1'b1, 1'b0, 32'h4000_0000, 32'h0,          3, 32'h2222_2222, 1'b0, 1'b0, 32'h0,          1'b1,  1};
    vecs[4] = '{1'b0, 1'b0, 32'h4000_0000, 32'h0,          3, 32'h3333_3333, 1'b0, 1'b0, 32'h0000_0013, 1'b0,  1};
    vecs[5] = '{1'b1, 1'b0, 32'h8012_3454, 32'h0,          2, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0,  4};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,          1, 32'h0040_0093, 1'b1, 1'b1, 32'h0040_0093, 1'b0,  3};
    vecs[7] = '{1'b1, 1'b0, 32'hF123_4567, 32'h0,          2, 32'h4444_4444, 1'b0, 1'b0, 32'h0,          1'b1,  1};

    rst_n = 1'b0;
    instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    repeat (3) tick();

    check("reset_instr_out", {instr_rdata[30:0], instr_done}, 32'h0);
    check("reset_data_out", {data_rdata[29:0], data_done, data_err}, 32'h0);
    check("reset_spi_ctl", {29'b0, spi_start, spi_dev, spi_we}, 32'h0);
    check("reset_spi_addr", {8'b0, spi_addr}, 32'h0);
    check("reset_spi_wdata", spi_wdata, 32'h0);
    check("reset_spi_abort", {31'b0, spi_abort}, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      eng_lat   = vecs[i].lat;
      eng_rdata = vecs[i].erd;
      run_txn(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, 100, rd, er, lat, st);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].x_rd);
      check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].x_err});
      check($sformatf("v%0d_latency", i), lat, vecs[i].x_lat);
      check($sformatf("v%0d_starts", i), st, {31'b0, vecs[i].x_start});
      if (vecs[i].x_start) begin
        check($sformatf("v%0d_spi_dev", i), {31'b0, cap_dev}, {31'b0, vecs[i].x_dev});
        check($sformatf("v%0d_spi_we", i), {31'b0, cap_we}, {31'b0, vecs[i].is_d & vecs[i].we});
        check($sformatf("v%0d_spi_addr", i), {8'b0, cap_addr}, {8'b0, vecs[i].addr[23:0]});
        if (vecs[i].is_d && vecs[i].we)
          check($sformatf("v%0d_spi_wdata", i), cap_wdata, vecs[i].wdata);
      end
    end

    // Both ports held: data gets MAXB grants in a row, then the fetch is forced through
    eng_lat = 2;
    order.delete();
    s0 = n_start;
    instr_addr = 32'h8000_0000;
    data_addr  = 32'h0000_0010;
    data_we    = 1'b0;
    instr_req  = 1'b1;
    data_req   = 1'b1;
    for (int k = 0; k < 500 && (n_start - s0) < 10; k++) tick();
    instr_req = 1'b0;
    data_req  = 1'b0;
    repeat (10) tick();
    check("fair_start_count", n_start - s0, 10);
    sc = 0;
    for (int i = 0; i < 10 && i < order.size(); i++) begin
      exp_dev = (sc < MAXB);
      if (exp_dev) sc++;
      else         sc = 0;
      check($sformatf("fair_grant%0d_is_data", i), {31'b0, order[i]}, {31'b0, exp_dev});
    end

    for (int i = 0; i < 40; i++) begin
      bit          is_d, we, xst, xdev, xerr;
      logic [31:0] a, wd, erd, xrd, tmp;
      logic [3:0]  nib;
      int          lt;
      is_d = 1'($urandom_range(0, 1));
      we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      case ($urandom_range(0, 3))
        0:       nib = 4'h0;
        1:       nib = 4'h8;
        2:       nib = 4'h4;
        default: nib = 4'($urandom_range(0, 15));
      endcase
      tmp = $urandom();
      a   = {nib, tmp[27:0]};
      wd  = $urandom();
      erd = $urandom();
      lt  = $urandom_range(1, 6);
      ref_model(is_d, we, a, erd, xst, xdev, xrd, xerr);
      eng_lat   = lt;
      eng_rdata = erd;
      run_txn(is_d, we, a, wd, 100, rd, er, lat, st);
      check($sformatf("rnd%0d_rdata", i), rd, xrd);
      check($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, xerr});
      check($sformatf("rnd%0d_latency", i), lat, xst ? lt + 2 : 1);
      check($sformatf("rnd%0d_starts", i), st, {31'b0, xst});
      if (xst) begin
        check($sformatf("rnd%0d_spi_dev", i), {31'b0, cap_dev}, {31'b0, xdev});
        check($sformatf("rnd%0d_spi_addr", i), {8'b0, cap_addr}, {8'b0, a[23:0]});
      end
    end
    check("spi_fields_stable", unstable, 0);

    // Reset while the engine never answers: back to IDLE with no completion
    eng_en = 1'b0;
    s0 = n_start;
    nd = 0;
    data_addr = 32'h0000_0100; data_we = 1'b0; data_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (data_done || instr_done) nd++;
    end
    check("rst_wait_started", n_start - s0, 1);
    rst_n = 1'b0;
    data_req = 1'b0;
    tick();
    if (data_done || instr_done) nd++;
    check("rst_wait_spi_abort", {31'b0, spi_abort}, 32'h0);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      if (data_done || instr_done) nd++;
    end
    check("rst_wait_no_done", nd, 0);
    check("rst_wait_spi_addr_cleared", {8'b0, spi_addr}, 32'h0);
    eng_en = 1'b1;
    eng_lat = 2;
    eng_rdata = 32'h5A5A_A5A5;
    run_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 100, rd, er, lat, st);
    check("after_rst_rdata", rd, 32'h5A5A_A5A5);
    check("after_rst_latency", lat, 4);

`ifdef SPI_ARB_TIMEOUT_EN
    eng_en = 1'b0;
    nd = n_abort;
    s0 = cyc;
    run_txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 1200, rd, er, lat, st);
    check("to_data_rdata", rd, 32'hDEAD_BEEF);
    check("to_data_err", {31'b0, er}, 32'h1);
    check("to_data_latency", lat, 1026);
    check("to_data_abort_count", n_abort - nd, 1);
    check("to_data_abort_cycle", abort_cyc - s0, 1025);
    nd = n_abort;
    run_txn(1'b0, 1'b0, 32'h8000_0400, 32'h0, 1200, rd, er, lat, st);
    check("to_instr_rdata", rd, 32'hDEAD_BEEF);
    check("to_instr_err", {31'b0, er}, 32'h0);
    check("to_instr_abort_count", n_abort - nd, 1);
    eng_en = 1'b1;
`else
    check("abort_never_pulsed", n_abort, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
Arbitrates the single shared SPI master (flash and RAM chip-selects) between the core's instruction-fetch port and data load/store port. Decodes the target device from the address, serialises one transaction at a time and returns read data with a done pulse. Sits between rv32i_core and the SPI transaction engine, replacing ad-hoc sharing inside the memory controller.

Parameters:
MAX_DATA_BURST, 4, consecutive data grants allowed while instr_req pending before instr is forced.
FLASH_REGION, 4'h8, addr[31:28] value selecting SPI flash.
RAM_REGION, 4'h0, addr[31:28] value selecting SPI RAM.
TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit (used only with SPI_ARB_TIMEOUT_EN).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
instr_req  in  1  fetch request, held until instr_done
instr_addr  in  32  fetch address
instr_rdata  out  32  fetch data, valid with instr_done
instr_done  out  1  one-cycle completion pulse
data_req  in  1  load/store request, held until data_done
data_we  in  1  1=write, 0=read
data_addr  in  32  data address
data_wdata  in  32  write data
data_rdata  out  32  read data, valid with data_done
data_done  out  1  one-cycle completion pulse
data_err  out  1  with data_done: decode error or write to flash
spi_start  out  1  one-cycle transaction start
spi_dev  out  1  0=flash, 1=RAM
spi_we  out  1  write transaction
spi_addr  out  24  device address (addr[23:0])
spi_wdata  out  32  write data
spi_done  in  1  engine completion pulse
spi_rdata  in  32  engine read data, valid with spi_done
spi_abort  out  1  abort pulse (SPI_ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset: state IDLE; all outputs 0; starvation counter 0; owner register = none.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; ERR path: IDLE -> RESP directly.
- IDLE: sample requests. Winner: data if data_req and (!instr_req or starve_cnt < MAX_DATA_BURST); else instr. Latch owner, addr, we, wdata, decoded device.
- Decode: addr[31:28]==FLASH_REGION -> dev 0; ==RAM_REGION -> dev 1; otherwise error. Data write to flash = error. Instr to non-flash/RAM region = instr_done with instr_rdata 32'h0000_0013 (NOP).
- Errors skip the SPI engine: RESP next cycle, data_err=1, data_rdata=0.
- ISSUE: spi_start=1 exactly one cycle; spi_dev/spi_we/spi_addr/spi_wdata stable from ISSUE until spi_done.
- WAIT: hold until spi_done; capture spi_rdata into owner's rdata register.
- RESP: owner's done pulsed one cycle; rdata held stable until next done for that port.
- Minimum latency, request seen in IDLE at cycle N: spi_start at N+1, done at cycle after spi_done. Error path: done at N+1.
- starve_cnt: increments on data grant while instr_req high; clears on instr grant or when instr_req low; saturates at MAX_DATA_BURST.
- Requesters must not drop req before done; dropping req mid-transaction does not cancel it.
- Request re-asserted in the same cycle as done is ignored: IDLE is re-entered after RESP, and arbitration happens there.
- Simultaneous req: data priority subject to starvation rule.
- Reset mid-transaction: returns to IDLE immediately; no done pulse; no spi_abort.

Optional Feature:
SPI_ARB_TIMEOUT_EN: WAIT counts cycles. At TIMEOUT_CYCLES without spi_done: pulse spi_abort one cycle, go to RESP with rdata=32'hDEAD_BEEF, and data_err=1 if owner is data. Without the macro: no counter, spi_abort tied 0, WAIT indefinite.

Decomposition:
- Package spi_arb_pkg: state encoding, owner encoding (OWN_NONE/INSTR/DATA), device codes, NOP and DEAD_BEEF constants.
- Sub-module spi_arb_decode: combinational address-to-device/error decode, instantiated once per port.

Test Plan:
- instr_req, addr 0x8000_0100; spi_done after 10 cycles, rdata 0x0000_0513 -> spi_start cycle 1, spi_dev=0, spi_addr=0x000100; instr_done with 0x0000_0513.
- data write, addr 0x0000_0040, wdata 0x1234_5678 -> spi_dev=1, spi_we=1, spi_wdata=0x1234_5678; data_done, data_err=0.
- data_req and instr_req both held continuously -> grant order D,D,D,D,I,D...
- data write to 0x8000_0000 -> no spi_start; data_done next cycle, data_err=1, data_rdata=0.
- data read from 0x4000_0000 -> data_err=1; instr fetch from 0x4000_0000 -> instr_rdata 0x0000_0013.
- SPI_ARB_TIMEOUT_EN with spi_done never asserted -> spi_abort at WAIT cycle 1024; done with 0xDEAD_BEEF; rst_n low in WAIT -> IDLE, no done.
